// File: rtl/aes_dma_if.sv
// Bundles the DMA control, data-memory port and AES-core handshakes between aes_dma and its environment.
interface aes_dma_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              busy;
  logic              done;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_a;
  logic [15:0]       mem_d;
  logic [15:0]       mem_q;
  logic              aes_in_valid;
  logic              aes_in_ready;
  logic [127:0]      aes_in_data;
  logic              aes_out_valid;
  logic              aes_out_ready;
  logic [127:0]      aes_out_data;

  modport master (
    input  start, src_addr, dst_addr, mem_q, aes_in_ready, aes_out_valid, aes_out_data,
    output busy, done, mem_wen, mem_a, mem_d, aes_in_valid, aes_in_data, aes_out_ready
  );

  modport slave (
    output start, src_addr, dst_addr, mem_q, aes_in_ready, aes_out_valid, aes_out_data,
    input  busy, done, mem_wen, mem_a, mem_d, aes_in_valid, aes_in_data, aes_out_ready
  );
endinterface

// File: rtl/aes_dma.sv
// Moves one 8-word block from data memory through an AES core and writes the result back.
module aes_dma #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BLK_WORDS = 8
) (
  input  logic      CLK,
  input  logic      RESET,
  aes_dma_if.master bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BLK_W  = WORD_W * BLK_WORDS;
  localparam int unsigned CNT_W  = $clog2(BLK_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(BLK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(BLK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, READ, PUSH, WAIT, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic              in_valid_q, in_valid_d;
  logic              out_ready_q, out_ready_d;

  // Word 0 occupies the most significant slice of the block.
  function automatic logic [WORD_W-1:0] word_at(input logic [BLK_W-1:0] b,
                                                input logic [CNT_W-1:0] k);
    return WORD_W'(b >> (WORD_W * (BLK_WORDS - 1 - 32'(k))));
  endfunction

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    src_d       = src_q;
    dst_d       = dst_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wen_d       = 1'b0;
    a_d         = '0;
    wd_d        = '0;
    in_valid_d  = 1'b0;
    out_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          cnt_d   = '0;
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
        end
      end
      READ: begin
        // Registered memory: the word addressed in cycle k arrives in cycle k+1.
        if (cnt_q != '0) blk_d = {blk_q[BLK_W-WORD_W-1:0], bus.mem_q};
        if (cnt_q == LAST_RD) begin
          state_d = PUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The local valid/ready is high throughout these states, so only the far side gates.
      PUSH: if (bus.aes_in_ready) state_d = WAIT;
      WAIT: begin
        if (bus.aes_out_valid) begin
          blk_d   = bus.aes_out_data;
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_WR) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    wen_d       = (state_d == WRITE);
    in_valid_d  = (state_d == PUSH);
    out_ready_d = (state_d == WAIT);
    if (state_d == READ && cnt_d != LAST_RD) a_d = src_d + ADDR_W'(cnt_d);
    if (state_d == WRITE) begin
      a_d  = dst_d + ADDR_W'(cnt_d);
      wd_d = word_at(blk_d, cnt_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wen_q       <= 1'b0;
      a_q         <= '0;
      wd_q        <= '0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      wd_q        <= wd_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_a         = a_q;
  assign bus.mem_d         = wd_q;
  assign bus.aes_in_valid  = in_valid_q;
  assign bus.aes_in_data   = blk_q;
  assign bus.aes_out_ready = out_ready_q;

endmodule

// File: doc/aes_dma.md
AES_DMA -- requirements
Module: aes_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, data-memory word-address width (512 x 16-bit words).
REQ-002 SHALL have parameter BLK_WORDS, default 8, words per AES block (128 bits / 16); other values unsupported.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a block transfer; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  word address of the first plaintext word; latched on accepted start.
REQ-007 dst_addr  input  ADDR_W  word address of the first result word; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the result write-back completes.
REQ-010 mem_wen  output  1  data-memory write enable.
REQ-011 mem_a  output  ADDR_W  data-memory address.
REQ-012 mem_d  output  16  data-memory write data.
REQ-013 mem_q  input  16  data-memory read data; valid one cycle after the address is presented (registered read).
REQ-014 aes_in_valid / aes_in_ready  output / input  1 / 1  plaintext handshake to the AES core.
REQ-015 aes_in_data  output  128  plaintext block.
REQ-016 aes_out_valid / aes_out_ready  input / output  1 / 1  result handshake from the AES core.
REQ-017 aes_out_data  input  128  result block.

Function
REQ-018 FSM states SHALL be IDLE, READ, PUSH, WAIT, WRITE, DONE.
REQ-019 IDLE: start=1 SHALL latch src_addr/dst_addr, clear the word counter, and go to READ next cycle; start is ignored in all other states.
REQ-020 READ: SHALL drive mem_a = src+k (mod 2^ADDR_W) in READ cycle k, k=0..7, with mem_wen=0.
REQ-021 READ: mem_q SHALL be captured in cycle k+1 as word k; word 0 -> block[127:112], word 7 -> block[15:0]; READ SHALL last exactly 9 cycles, then PUSH.
REQ-022 PUSH: aes_in_valid=1, aes_in_data=captured block held stable; transfer when aes_in_valid & aes_in_ready; next cycle WAIT.
REQ-023 WAIT: aes_out_ready=1; on aes_out_valid & aes_out_ready, aes_out_data SHALL be captured into the block register; next cycle WRITE.
REQ-024 WRITE: in cycle k (k=0..7), mem_wen=1, mem_a = dst+k (mod 2^ADDR_W), mem_d = result word k (same word ordering as REQ-021); after 8 cycles go to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; start is not accepted in DONE.
REQ-026 aes_in_valid SHALL be 1 only in PUSH; aes_out_ready only in WAIT; mem_wen only in WRITE.
REQ-027 In IDLE, PUSH, WAIT and DONE, mem_a SHALL be 0 and mem_d SHALL be 0.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W (e.g. src=510 reads 510,511,0..5).
REQ-029 Overlapping or identical src/dst ranges SHALL be legal; all reads complete before any write.
REQ-030 No timeout: PUSH and WAIT SHALL hold indefinitely until the handshake completes.

Reset
REQ-031 RESET=1 at a clock edge SHALL force IDLE and clear the counter, block register and latched addresses; busy, done, mem_wen, aes_in_valid and aes_out_ready SHALL be 0 and mem_a/mem_d SHALL be 0 from the next cycle.
REQ-032 RESET mid-operation SHALL abort the transfer with no further memory writes; words already written remain; start is ignored while RESET=1.

Verification
REQ-033 Basic: mem[16..23]=0x0001..0x0008, start src=16 dst=32, AES model returns input XOR {8{16'hFFFF}} after 3 cycles -> mem[32..39]=0xFFFE..0xFFF7, done pulses once, busy high from cycle after start until done.
REQ-034 Timing: aes_in_ready tied 1, result 1 cycle later -> first mem_a=16 in the cycle after start, aes_in_valid in cycle 10, mem_wen high for exactly 8 consecutive cycles.
REQ-035 Wrap: src=508 dst=510 -> reads 508..511,0..3; writes 510,511,0..5.
REQ-036 Backpressure: aes_in_ready low 20 cycles, then aes_out_valid delayed 15 cycles -> aes_in_data stable throughout, no memory write before result capture, correct data written.
REQ-037 Reset mid-WRITE: RESET asserted in WRITE cycle 3 -> only dst+0..dst+3 written, next cycle busy=0, mem_wen=0, done never pulses.
REQ-038 Start while busy: second start pulse during WAIT -> ignored; exactly one done, latched addresses unchanged.
